// File: rtl/axi_lite_ram_slave.sv
// AXI4-Lite slave in front of a word-addressed 1R1W RAM.
// Read and write paths are independent FSMs; every output is a register.
module axi_lite_ram_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ADDR_BITS = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] axi_araddr,
    input  logic [2:0]  axi_arprot,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp,
    output logic        axi_rvalid,
    input  logic        axi_rready,
    input  logic [31:0] axi_awaddr,
    input  logic [2:0]  axi_awprot,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    input  logic        axi_wvalid,
    output logic        axi_wready,
    output logic [1:0]  axi_bresp,
    output logic        axi_bvalid,
    input  logic        axi_bready
);

    localparam int          DEPTH       = 1 << ADDR_BITS;
    localparam logic [32:0] SPAN        = 33'd4 << ADDR_BITS;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    localparam logic [1:0] R_IDLE   = 2'd0;
    localparam logic [1:0] R_READ   = 2'd1;
    localparam logic [1:0] R_RESP   = 2'd2;
    localparam logic [1:0] W_IDLE   = 2'd0;
    localparam logic [1:0] W_COMMIT = 2'd1;
    localparam logic [1:0] W_RESP   = 2'd2;

    function automatic logic in_range(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return ({1'b0, off} < SPAN);
    endfunction

    function automatic logic [ADDR_BITS-1:0] word_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return off[ADDR_BITS+1:2];
    endfunction

    logic [31:0]          r_mem [0:DEPTH-1];
    logic [31:0]          r_ram_q;

    logic [1:0]           r_rstate;
    logic [ADDR_BITS-1:0] r_ar_idx;
    logic                 r_ar_ok;
    logic                 r_ram_vld;
    logic                 r_arready;
    logic                 r_rvalid;
    logic [31:0]          r_rdata;
    logic [1:0]           r_rresp;

    logic [1:0]           r_wstate;
    logic [ADDR_BITS-1:0] r_aw_idx;
    logic                 r_aw_ok;
    logic                 r_aw_held;
    logic                 r_w_held;
    logic [31:0]          r_wdata;
    logic [3:0]           r_wstrb;
    logic                 r_awready;
    logic                 r_wready;
    logic                 r_bvalid;
    logic [1:0]           r_bresp;

    logic w_ar_hs;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_commit;
    logic w_unused_prot;

    assign w_ar_hs       = axi_arvalid & r_arready;
    assign w_aw_hs       = axi_awvalid & r_awready;
    assign w_w_hs        = axi_wvalid & r_wready;
    assign w_commit      = (r_wstate == W_COMMIT);
    assign w_unused_prot = ^{axi_arprot, axi_awprot};

    // Non-blocking read of the old word makes a same-edge read/commit read-first.
    always_ff @(posedge clk) begin
        r_ram_q <= r_mem[r_ar_idx];
        if (w_commit && r_aw_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (r_wstrb[i]) begin
                    r_mem[r_aw_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read path: R_READ spends one edge issuing the RAM read and one capturing it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate  <= R_IDLE;
            r_ar_idx  <= '0;
            r_ar_ok   <= 1'b0;
            r_ram_vld <= 1'b0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_ar_idx  <= word_idx(axi_araddr);
                        r_ar_ok   <= in_range(axi_araddr);
                        r_arready <= 1'b0;
                        r_ram_vld <= 1'b0;
                        r_rstate  <= R_READ;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_READ: begin
                    if (!r_ram_vld) begin
                        r_ram_vld <= 1'b1;
                    end else begin
                        r_rdata   <= r_ar_ok ? r_ram_q : 32'h0;
                        r_rresp   <= r_ar_ok ? RESP_OKAY : RESP_DECERR;
                        r_rvalid  <= 1'b1;
                        r_ram_vld <= 1'b0;
                        r_rstate  <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (axi_rready) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    // Write path: AW and W are collected independently, commit once both are held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate  <= W_IDLE;
            r_aw_idx  <= '0;
            r_aw_ok   <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_aw_idx  <= word_idx(axi_awaddr);
                        r_aw_ok   <= in_range(axi_awaddr);
                        r_awready <= 1'b0;
                        r_aw_held <= 1'b1;
                    end else if (!r_aw_held) begin
                        r_awready <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wdata  <= axi_wdata;
                        r_wstrb  <= axi_wstrb;
                        r_wready <= 1'b0;
                        r_w_held <= 1'b1;
                    end else if (!r_w_held) begin
                        r_wready <= 1'b1;
                    end
                    if ((r_aw_held || w_aw_hs) && (r_w_held || w_w_hs)) begin
                        r_wstate <= W_COMMIT;
                    end
                end
                W_COMMIT: begin
                    r_bvalid  <= 1'b1;
                    r_bresp   <= r_aw_ok ? RESP_OKAY : RESP_DECERR;
                    r_aw_held <= 1'b0;
                    r_w_held  <= 1'b0;
                    r_wstate  <= W_RESP;
                end
                W_RESP: begin
                    if (axi_bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    assign axi_arready = r_arready;
    assign axi_rdata   = r_rdata;
    assign axi_rresp   = r_rresp;
    assign axi_rvalid  = r_rvalid;
    assign axi_awready = r_awready;
    assign axi_wready  = r_wready;
    assign axi_bresp   = r_bresp;
    assign axi_bvalid  = r_bvalid;

endmodule

// File: tb/tb_axi_lite_ram_slave.sv
// Directed and randomized bench for axi_lite_ram_slave against an associative-array
// memory model; inputs change on the falling edge, outputs are sampled there too.
module tb_axi_lite_ram_slave;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          AB   = 12;

    logic        clk;
    logic        rst;
    logic [31:0] axi_araddr;
    logic [2:0]  axi_arprot;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready;
    logic [31:0] axi_awaddr;
    logic [2:0]  axi_awprot;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;

    axi_lite_ram_slave #(.BASE_ADDR(BASE), .ADDR_BITS(AB)) dut (
        .clk(clk), .rst(rst),
        .axi_araddr(axi_araddr), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid),
        .axi_arready(axi_arready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid),
        .axi_awready(axi_awready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_bresp(axi_bresp),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] mdl [int];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expired(input string tag);
        n_assert++;
        n_fail++;
        $error("FAIL %s bound expired waiting for DUT", tag);
    endtask

    // RAM spans 4 << 12 = 0x4000 bytes above BASE.
    function automatic bit mdl_in(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off < 32'h4000;
    endfunction

    function automatic int mdl_idx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic logic [1:0] mdl_resp(input logic [31:0] a);
        return mdl_in(a) ? 2'b00 : 2'b11;
    endfunction

    task automatic mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        if (mdl_in(a)) begin
            w = mdl.exists(mdl_idx(a)) ? mdl[mdl_idx(a)] : 32'h0;
            for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
            mdl[mdl_idx(a)] = w;
        end
    endtask

    function automatic logic [31:0] mdl_read(input logic [31:0] a);
        return mdl_in(a) ? mdl[mdl_idx(a)] : 32'h0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        axi_arvalid = 1'b0; axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        axi_rready = 1'b0; axi_bready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_readies", 32'({axi_arready, axi_awready, axi_wready}), 32'h0);
        chk("rst_valids", 32'({axi_rvalid, axi_bvalid}), 32'h0);
        chk("rst_rdata", axi_rdata, 32'h0);
        chk("rst_resps", 32'({axi_rresp, axi_bresp}), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'({axi_arready, axi_awready, axi_wready}), 32'h7);
    endtask

    // AW/W handshakes; each valid is raised after its own delay and held until ready.
    task automatic wr_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly);
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        bit aw_hs;
        bit w_hs;
        int cyc = 0;
        while (!(aw_done && w_done)) begin
            if (cyc > 40) begin
                expired("wr_req");
                break;
            end
            @(negedge clk);
            axi_awaddr = a; axi_wdata = d; axi_wstrb = s;
            axi_awvalid = !aw_done && (cyc >= aw_dly);
            axi_wvalid  = !w_done && (cyc >= w_dly);
            if (aw_done && !w_done) begin
                chk("awready_low_wait_w", 32'(axi_awready), 32'h0);
                chk("no_b_before_w", 32'(axi_bvalid), 32'h0);
            end
            if (w_done && !aw_done) begin
                chk("wready_low_wait_aw", 32'(axi_wready), 32'h0);
                chk("no_b_before_aw", 32'(axi_bvalid), 32'h0);
            end
            aw_hs = axi_awvalid && axi_awready;
            w_hs  = axi_wvalid && axi_wready;
            @(posedge clk);
            aw_done = aw_done | aw_hs;
            w_done  = w_done | w_hs;
            cyc++;
        end
        mdl_write(a, d, s);
    endtask

    task automatic wr_resp(input int bdly, input logic [1:0] exp_r);
        int t = 0;
        do begin
            @(negedge clk);
            axi_awvalid = 1'b0; axi_wvalid = 1'b0;
            t++;
        end while (!axi_bvalid && t < 20);
        if (!axi_bvalid) begin
            expired("bvalid");
            return;
        end
        chk("b_latency", 32'(t), 32'd2);
        chk("bresp", 32'(axi_bresp), 32'(exp_r));
        repeat (bdly) begin
            @(negedge clk);
            chk("bvalid_hold", 32'(axi_bvalid), 32'h1);
            chk("bresp_hold", 32'(axi_bresp), 32'(exp_r));
            chk("aw_w_ready_low", 32'({axi_awready, axi_wready}), 32'h0);
        end
        axi_bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        axi_bready = 1'b0;
        chk("bvalid_drop", 32'(axi_bvalid), 32'h0);
        chk("aw_w_ready_back", 32'({axi_awready, axi_wready}), 32'h3);
    endtask

    task automatic wr_full(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int bdly);
        wr_req(a, d, s, aw_dly, w_dly);
        wr_resp(bdly, mdl_resp(a));
    endtask

    task automatic rd_req(input logic [31:0] a);
        bit hs = 1'b0;
        int cyc = 0;
        while (!hs) begin
            if (cyc > 40) begin
                expired("rd_req");
                break;
            end
            @(negedge clk);
            axi_araddr = a;
            axi_arvalid = 1'b1;
            hs = axi_arready;
            @(posedge clk);
            cyc++;
        end
    endtask

    task automatic rd_resp(input int rdly, input logic [31:0] exp_d, input logic [1:0] exp_r);
        int t = 0;
        do begin
            @(negedge clk);
            axi_arvalid = 1'b0;
            t++;
            if (t == 1) chk("arready_low", 32'(axi_arready), 32'h0);
        end while (!axi_rvalid && t < 20);
        if (!axi_rvalid) begin
            expired("rvalid");
            return;
        end
        chk("r_latency", 32'(t), 32'd3);
        chk("rdata", axi_rdata, exp_d);
        chk("rresp", 32'(axi_rresp), 32'(exp_r));
        repeat (rdly) begin
            @(negedge clk);
            chk("rvalid_hold", 32'(axi_rvalid), 32'h1);
            chk("rdata_hold", axi_rdata, exp_d);
            chk("arready_low_hold", 32'(axi_arready), 32'h0);
        end
        axi_rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        axi_rready = 1'b0;
        chk("rvalid_drop", 32'(axi_rvalid), 32'h0);
        chk("arready_back", 32'(axi_arready), 32'h1);
    endtask

    task automatic rd_full(input logic [31:0] a, input int rdly,
                           input logic [31:0] exp_d, input logic [1:0] exp_r);
        rd_req(a);
        rd_resp(rdly, exp_d, exp_r);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        rst = 1'b0;
        axi_araddr = '0; axi_arprot = '0; axi_arvalid = 1'b0; axi_rready = 1'b0;
        axi_awaddr = '0; axi_awprot = '0; axi_awvalid = 1'b0;
        axi_wdata = '0; axi_wstrb = '0; axi_wvalid = 1'b0; axi_bready = 1'b0;

        do_reset();

        // Basic write then read, AW and W together.
        wr_full(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        rd_full(32'h10, 0, 32'hDEADBEEF, 2'b00);

        // Byte strobes.
        wr_full(32'h20, 32'h11223344, 4'hF, 0, 0, 0);
        wr_full(32'h20, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
        rd_full(32'h20, 0, 32'h11BB33DD, 2'b00);

        // W three cycles ahead of AW, then AW three cycles ahead of W.
        wr_full(32'h30, 32'hCAFEF00D, 4'hF, 3, 0, 0);
        rd_full(32'h30, 0, 32'hCAFEF00D, 2'b00);
        wr_full(32'h34, 32'h01234567, 4'hF, 0, 3, 0);
        rd_full(32'h34, 0, 32'h01234567, 2'b00);

        // Backpressure on B and R.
        wr_full(32'h40, 32'h5A5A5A5A, 4'hF, 0, 0, 4);
        rd_full(32'h40, 5, 32'h5A5A5A5A, 2'b00);

        // Out-of-range decode, including an address that wraps below BASE.
        wr_full(32'h0, 32'h13579BDF, 4'hF, 0, 0, 0);
        wr_full(32'h4000, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        chk("oor_bresp_model", 32'(mdl_resp(32'h4000)), 32'h3);
        rd_full(32'h0, 0, 32'h13579BDF, 2'b00);
        rd_full(32'h4000, 0, 32'h0, 2'b11);
        rd_full(32'hFFFF_FFF0, 1, 32'h0, 2'b11);

        // Reset while a read is in R_READ.
        rd_req(32'h10);
        @(negedge clk);
        axi_arvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("rvalid_after_abort", 32'(axi_rvalid), 32'h0);
        end
        chk("ready_after_rd_abort", 32'({axi_arready, axi_awready, axi_wready}), 32'h7);

        // Reset while the write response is pending.
        wr_req(32'h50, 32'h0BADF00D, 4'hF, 0, 0);
        @(negedge clk);
        axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        @(negedge clk);
        chk("bvalid_before_abort", 32'(axi_bvalid), 32'h1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("bvalid_after_abort", 32'(axi_bvalid), 32'h0);
        end
        chk("ready_after_wr_abort", 32'({axi_arready, axi_awready, axi_wready}), 32'h7);
        wr_full(32'h60, 32'h600DCAFE, 4'hF, 1, 0, 0);
        rd_full(32'h60, 0, 32'h600DCAFE, 2'b00);
        rd_full(32'h50, 0, 32'h0BADF00D, 2'b00);

        // Randomized traffic over 16 words, with occasional out-of-range accesses.
        for (int i = 0; i < 16; i++) wr_full(32'h100 + 32'(4 * i), $urandom, 4'hF, 0, 0, 0);
        for (int n = 0; n < 60; n++) begin
            a = 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = 32'h4000 + 32'($urandom_range(0, 32'hFFFF));
            d = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                wr_full(a, d, 4'($urandom), int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
            end else begin
                rd_full(a, int'($urandom_range(0, 2)), mdl_read(a), mdl_resp(a));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
